// File: rtl/iir_result_writer.sv
// IIR result writer: buffers the filter result stream in a FIFO and drains it to result memory over req/gnt.
// Optional running checksum of committed words is enabled by defining IIR_WR_CHECKSUM_EN.
module iir_result_writer #(
    parameter int              DEPTH    = 8,
    parameter int              AW       = 20,
    parameter int              DW       = 16,
    parameter logic [AW-1:0]   OUT_BASE = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_wen,
    input  logic [AW-1:0]              in_addr,
    input  logic [DW-1:0]              in_data,
    input  logic                       in_finish,
    output logic                       mem_req,
    input  logic                       mem_gnt,
    output logic [AW-1:0]              mem_addr,
    output logic [DW-1:0]              mem_wdata,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       overflow,
    output logic                       done,
    output logic [DW-1:0]              checksum
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = AW + DW;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACTIVE = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic [EW-1:0] fifo_q [DEPTH];

    logic          accepting;
    logic          empty;
    logic          full;
    logic          pop;
    logic          push;
    logic          drop;
    logic [AW-1:0] push_addr;
    logic [EW-1:0] head;

    assign accepting = (state_q == S_IDLE) || (state_q == S_ACTIVE);
    assign empty     = (count_q == '0);
    assign full      = (count_q == CW'(DEPTH));

    // Request depends only on registered state so memory sees no combinational path from in_*.
    assign mem_req   = !empty && (state_q != S_DONE);
    assign pop       = mem_req && mem_gnt;
    assign push      = in_wen && accepting && (!full || pop);
    assign drop      = in_wen && accepting && full && !pop;
    assign push_addr = in_addr + OUT_BASE;

    assign head      = fifo_q[rd_ptr_q];
    assign mem_addr  = mem_req ? head[EW-1:DW] : '0;
    assign mem_wdata = mem_req ? head[DW-1:0] : '0;

    assign fifo_count = count_q;
    assign overflow   = ovf_q;
    assign done       = (state_q == S_DONE);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_finish) begin
                    state_d = S_DRAIN;
                end else if (push) begin
                    state_d = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (in_finish) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (empty) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        ovf_d    = ovf_q || drop;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // When full with a pop this cycle, wr_ptr equals rd_ptr: the freed slot is refilled.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= {push_addr, in_data};
        end
    end

`ifdef IIR_WR_CHECKSUM_EN
    logic [DW-1:0] csum_q, csum_d;

    assign csum_d   = pop ? csum_q + mem_wdata : csum_q;
    assign checksum = csum_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_iir_result_writer.sv
// Directed self-checking bench for iir_result_writer.
// Second instance uses a wrapping OUT_BASE and shares the stimulus.
module tb_iir_result_writer;

    logic        clk;
    logic        rst;
    logic        in_wen;
    logic [19:0] in_addr;
    logic [15:0] in_data;
    logic        in_finish;
    logic        mem_gnt;

    logic        mem_req;
    logic [19:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [3:0]  fifo_count;
    logic        overflow;
    logic        done;
    logic [15:0] checksum;

    logic        w_mem_req;
    logic [19:0] w_mem_addr;
    logic [15:0] w_mem_wdata;
    logic [3:0]  w_fifo_count;
    logic        w_overflow;
    logic        w_done;
    logic [15:0] w_checksum;

    int n_chk;
    int n_fail;
    int idx;

`ifdef IIR_WR_CHECKSUM_EN
    localparam logic [15:0] CS1 = 16'd15;
    localparam logic [15:0] CS4 = 16'h0086;
    localparam logic [15:0] CS6 = 16'd5;
`else
    localparam logic [15:0] CS1 = 16'd0;
    localparam logic [15:0] CS4 = 16'd0;
    localparam logic [15:0] CS6 = 16'd0;
`endif

    iir_result_writer #(
        .DEPTH(8), .AW(20), .DW(16), .OUT_BASE(20'd16)
    ) dut (
        .clk(clk), .rst(rst),
        .in_wen(in_wen), .in_addr(in_addr), .in_data(in_data),
        .in_finish(in_finish),
        .mem_req(mem_req), .mem_gnt(mem_gnt),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .fifo_count(fifo_count), .overflow(overflow),
        .done(done), .checksum(checksum)
    );

    iir_result_writer #(
        .DEPTH(8), .AW(20), .DW(16), .OUT_BASE(20'hFFFFE)
    ) dut_w (
        .clk(clk), .rst(rst),
        .in_wen(in_wen), .in_addr(in_addr), .in_data(in_data),
        .in_finish(in_finish),
        .mem_req(w_mem_req), .mem_gnt(mem_gnt),
        .mem_addr(w_mem_addr), .mem_wdata(w_mem_wdata),
        .fifo_count(w_fifo_count), .overflow(w_overflow),
        .done(w_done), .checksum(w_checksum)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_wen    = 1'b0;
        in_finish = 1'b0;
        mem_gnt   = 1'b0;
        in_addr   = '0;
        in_data   = '0;
        rst       = 1'b1;
        tick();
        rst       = 1'b0;
    endtask

    task automatic push_n(input int n, input logic [15:0] base);
        for (int i = 0; i < n; i++) begin
            in_wen  = 1'b1;
            in_addr = 20'(i);
            in_data = base + 16'(i);
            tick();
        end
        in_wen = 1'b0;
    endtask

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        rst       = 1'b0;
        in_wen    = 1'b0;
        in_finish = 1'b0;
        mem_gnt   = 1'b0;
        in_addr   = '0;
        in_data   = '0;
        #1 rst = 1'b1;
        #1;
        check("rst_req", mem_req, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_count", fifo_count, 0);
        check("rst_ovf", overflow, 0);
        check("rst_done", done, 0);
        check("rst_csum", checksum, 0);
        tick();
        rst = 1'b0;

        // streaming with gnt held high, one commit per cycle
        mem_gnt = 1'b1;
        for (int k = 0; k < 5; k++) begin
            in_wen  = 1'b1;
            in_addr = 20'(k);
            in_data = 16'(k + 1);
            tick();
            check("t1_req", mem_req, 1);
            check("t1_addr", mem_addr, 32'(16 + k));
            check("t1_data", mem_wdata, 32'(k + 1));
            check("t1_count", fifo_count, 1);
            if (k == 3) check("wrap_addr", w_mem_addr, 20'h00001);
        end
        in_wen    = 1'b0;
        in_finish = 1'b1;
        tick();
        check("t1_empty", fifo_count, 0);
        check("t1_done_early", done, 0);
        in_finish = 1'b0;
        tick();
        check("t1_done", done, 1);
        check("t1_ovf", overflow, 0);
        check("t1_csum", checksum, CS1);

        // overflow with gnt low
        do_reset();
        push_n(8, 16'h0010);
        check("t2_full", fifo_count, 8);
        check("t2_ovf0", overflow, 0);
        in_wen  = 1'b1;
        in_addr = 20'd8;
        in_data = 16'h0018;
        tick();
        in_wen = 1'b0;
        check("t2_count", fifo_count, 8);
        check("t2_ovf1", overflow, 1);
        mem_gnt = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("t2_drain", mem_wdata, 32'(16'h0010 + i));
            tick();
        end
        check("t2_empty", fifo_count, 0);
        check("t2_req", mem_req, 0);
        check("t2_ovf_sticky", overflow, 1);

        // push into full fifo with simultaneous pop
        do_reset();
        push_n(8, 16'h0030);
        in_wen  = 1'b1;
        in_addr = 20'd0;
        in_data = 16'h0099;
        mem_gnt = 1'b1;
        tick();
        in_wen  = 1'b0;
        mem_gnt = 1'b0;
        check("t3_count", fifo_count, 8);
        check("t3_ovf", overflow, 0);
        check("t3_head", mem_wdata, 16'h0031);

        // gnt toggling keeps head stable across wait states
        do_reset();
        push_n(4, 16'h0020);
        idx = 0;
        for (int c = 0; c < 7; c++) begin
            mem_gnt = (c % 2 == 0);
            check("t4_addr", mem_addr, 32'(16 + idx));
            check("t4_data", mem_wdata, 32'(16'h0020 + idx));
            tick();
            if (mem_gnt) idx++;
        end
        mem_gnt = 1'b0;
        check("t4_empty", fifo_count, 0);
        in_finish = 1'b1;
        tick();
        in_finish = 1'b0;
        tick();
        check("t4_done", done, 1);
        check("t4_csum", checksum, CS4);

        // empty stream
        do_reset();
        in_finish = 1'b1;
        tick();
        check("t5_req_a", mem_req, 0);
        tick();
        check("t5_done", done, 1);
        check("t5_req_b", mem_req, 0);
        in_finish = 1'b0;
        in_wen    = 1'b1;
        tick();
        in_wen = 1'b0;
        check("t5_ignored", fifo_count, 0);
        check("t5_req_c", mem_req, 0);
        check("t5_done_hold", done, 1);

        // asynchronous reset with pending entries
        do_reset();
        mem_gnt = 1'b1;
        in_wen  = 1'b1;
        in_data = 16'd5;
        tick();
        in_data = 16'd6;
        tick();
        mem_gnt = 1'b0;
        in_data = 16'd7;
        tick();
        in_data = 16'd8;
        tick();
        in_wen = 1'b0;
        check("t6_count", fifo_count, 3);
        check("t6_req", mem_req, 1);
        check("t6_csum", checksum, CS6);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_req", mem_req, 0);
        check("t6_rst_count", fifo_count, 0);
        check("t6_rst_csum", checksum, 0);
        check("t6_rst_addr", mem_addr, 0);
        tick();
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/iir_result_writer.md
Name: iir_result_writer

Overview:
- Downstream stage of the IIR filter. Captures the filter's per-cycle result stream (write enable, address, 16-bit signed sample, finish flag) into a small FIFO.
- Drains the FIFO to result memory over a req/gnt handshake, so memory wait states do not lose samples.
- Signals completion only after every accepted sample has been committed.

Parameters:
- DEPTH, 8, FIFO entries; power of two, >= 2.
- AW, 20, address width.
- DW, 16, data width.
- OUT_BASE, 0, offset added to every incoming address, modulo 2^AW.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_wen  input  1  filter result valid this cycle.
- in_addr  input  AW  result address from filter.
- in_data  input  DW  signed result sample.
- in_finish  input  1  filter end-of-stream flag; level, sampled each cycle.
- mem_req  output  1  write request to result memory.
- mem_gnt  input  1  memory accepts the request this cycle.
- mem_addr  output  AW  write address.
- mem_wdata  output  DW  write data.
- fifo_count  output  $clog2(DEPTH)+1  current FIFO occupancy.
- overflow  output  1  sticky: a sample was dropped.
- done  output  1  stream fully committed; held until reset.
- checksum  output  DW  running sum of committed words (see Optional Feature).

Behaviour:
- Reset values: mem_req=0, mem_addr=0, mem_wdata=0, fifo_count=0, overflow=0, done=0, checksum=0. FSM=IDLE, FIFO pointers=0.
- Reset is asynchronous. Asserting rst mid-operation empties the FIFO and abandons any pending request; mem_req drops immediately.
- FSM states:
  - IDLE: no sample seen. First accepted push -> ACTIVE. If in_finish is sampled in IDLE -> DRAIN directly (empty stream).
  - ACTIVE: pushes accepted; FIFO drains. in_finish sampled high -> DRAIN.
  - DRAIN: in_wen ignored, nothing pushed, not counted as overflow. When the FIFO is empty and no transfer is pending -> DONE.
  - DONE: done=1 and mem_req=0. Terminal until rst; in_wen and in_finish ignored.
- Push rules:
  - A push occurs when in_wen=1, state is IDLE or ACTIVE, and the FIFO is not full.
  - Entry stored = {in_addr + OUT_BASE (wraps mod 2^AW), in_data}. The entry is visible at the head no earlier than the next cycle.
- Push when full:
  - If a pop completes in the same cycle, the push is accepted and fifo_count is unchanged.
  - Otherwise the sample is dropped and overflow is set; it stays set until rst.
- Pop / handshake:
  - mem_req = FIFO not empty and state != DONE. It is derived only from registered state.
  - mem_addr and mem_wdata show the head entry and are stable while mem_req=1 and mem_gnt=0.
  - A transfer completes on a rising edge where mem_req & mem_gnt = 1; the head is popped on that edge.
  - Back-to-back transfers are allowed: with mem_gnt held high, one word commits per cycle.
  - mem_gnt while mem_req=0 has no effect.
- Latency: a sample pushed at edge N can commit no earlier than edge N+1 (mem_gnt high in the cycle after the push).
- Ordering: strict FIFO; commit order equals push order.
- fifo_count: +1 on push only, -1 on pop only, unchanged on both or neither. Range 0..DEPTH.
- Pointers: wrap modulo DEPTH. Full/empty is decided from fifo_count, not pointer equality.
- done rises on the edge after the last commit, when the FIFO is empty in DRAIN.

Optional Feature:
- Macro IIR_WR_CHECKSUM_EN.
- Defined: checksum += mem_wdata on every completed transfer, wrapping mod 2^DW, treated as unsigned. Value is frozen once done=1; cleared by rst.
- Undefined: the checksum port exists but is tied to 0 and no adder is built.

Test Plan:
- Stream in_wen=1 for 5 cycles with addr 0..4, data 16'h0001..0005, OUT_BASE=16, mem_gnt=1 throughout, then in_finish=1 -> writes to addr 16..20 in order, one per cycle; done=1 one edge after the last commit; overflow=0; checksum=15 with macro, 0 without.
- mem_gnt=0 while 8 samples are pushed, then a 9th sample without a pop -> fifo_count=8, 9th sample dropped, overflow=1. Releasing mem_gnt then yields exactly 8 commits.
- FIFO full with mem_gnt=1 and in_wen=1 in the same cycle -> push accepted, fifo_count stays 8, overflow stays 0.
- mem_gnt toggling 1,0,1,0 with 4 queued samples -> mem_addr/mem_wdata hold stable during gnt=0 cycles; 4 commits total.
- in_finish=1 with no prior in_wen -> DONE on the following cycle, done=1, mem_req never asserted.
- OUT_BASE=20'hFFFFE with addr 3 -> mem_addr=20'h00001 (wrap).
- rst asserted with 3 entries pending and mem_req=1 -> mem_req=0 and fifo_count=0 immediately; checksum=0.
